fmps_stream_capture: RTL and testbench

Receiving end of the FMPS readout packet stream: consumes the `(fmpsIndex, fmpsData, fmpsValid)` stream produced on sysClk and rebuilds a per-FA-cycle FMPS snapshot that the microBlaze or downstream logic can address randomly. Storage is double-buffered, one bank collecting while the other is readable. Frames are delimited by `FAstrobe`, and per-frame presence bitmap, count, duplicate and overrun status are exported on a CSR word.

---
 rtl/fmps_capture_pkg.sv | 53 +++++
 rtl/fmps_capture_dpram.sv | 43 ++++
 rtl/fmps_stream_capture.sv | 172 +++++++++++++++++
 tb/tb_fmps_stream_capture.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fmps_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fmps_capture_pkg
// Purpose  : Shared constants for the FMPS stream capture block: CSR field
//            positions and widths, FSM state encoding, the GPIO clear bit and
//            the overrun saturation value, plus a CSR packing helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fmps_capture_pkg;

  // CSR field layout
  localparam int CSR_COLLECTING_BIT = 31;
  localparam int CSR_VALID_BIT      = 30;
  localparam int CSR_DUP_BIT        = 29;
  localparam int CSR_OVERRUN_LSB    = 20;
  localparam int CSR_OVERRUN_WIDTH  = 8;
  localparam int CSR_FRAME_LSB      = 12;
  localparam int CSR_FRAME_WIDTH    = 8;
  localparam int CSR_COUNT_LSB      = 0;
  localparam int CSR_COUNT_WIDTH    = 10;

  // GPIO_OUT bit that clears the overrun counter when csrStrobe is high
  localparam int GPIO_CLEAR_BIT = 0;

  localparam logic [CSR_OVERRUN_WIDTH-1:0] OVERRUN_SAT = 8'd255;

  typedef enum logic [0:0] {
    FSM_WAIT_SYNC = 1'b0,
    FSM_COLLECT   = 1'b1
  } fsm_state_t;

  function automatic logic [31:0] pack_csr(
    input logic                         collecting,
    input logic                         valid,
    input logic                         dup,
    input logic [CSR_OVERRUN_WIDTH-1:0] overrun,
    input logic [CSR_FRAME_WIDTH-1:0]   frames,
    input logic [CSR_COUNT_WIDTH-1:0]   count
  );
    logic [31:0] w;
    w = '0;
    w[CSR_COLLECTING_BIT]                         = collecting;
    w[CSR_VALID_BIT]                              = valid;
    w[CSR_DUP_BIT]                                = dup;
    w[CSR_OVERRUN_LSB +: CSR_OVERRUN_WIDTH]       = overrun;
    w[CSR_FRAME_LSB +: CSR_FRAME_WIDTH]           = frames;
    w[CSR_COUNT_LSB +: CSR_COUNT_WIDTH]           = count;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fmps_capture_dpram.sv
`default_nettype none
// ============================================================================
// Module   : fmps_capture_dpram
// Purpose  : Simple dual-port RAM holding both capture banks. The bank is the
//            MSB of the address. One write port, one registered read port
//            with read-before-write behaviour on an address collision.
// Ports    : clk      - clock
//            wr_en    - write enable
//            wr_addr  - write address {bank, slot}
//            wr_data  - write data
//            rd_addr  - read address {bank, slot}
//            rd_data  - registered read data (one cycle latency)
// Revision : 1.0 - initial release
// ============================================================================
module fmps_capture_dpram
  import fmps_capture_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Contents are deliberately not reset; the top gates reads with the
  // presence bitmap so stale words never reach the outputs.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule
`default_nettype wire

// File: rtl/fmps_stream_capture.sv
`default_nettype none
// ============================================================================
// Module   : fmps_stream_capture
// Purpose  : Rebuilds a per-FA-cycle FMPS snapshot from the (index, data,
//            valid) packet stream. Double-buffered: one bank collects while
//            the other is committed and randomly readable. FAstrobe closes a
//            frame; readoutHold turns a close into an overrun (frame dropped).
// Ports    : sysClk, sysReset         - clock, synchronous active-high reset
//            FAstrobe                 - frame boundary pulse
//            packetIndex/Data/Valid   - incoming packet stream
//            readoutHold              - freeze committed bank
//            csrStrobe, GPIO_OUT      - CSR write (bit 0 clears overruns)
//            readoutAddress           - committed-bank read address
//            readoutData/Present      - read result, one cycle latency
//            bitmap                   - committed presence bitmap
//            frameStrobe              - one-cycle pulse per commit
//            csr                      - status word
// Revision : 1.0 - initial release
// ============================================================================
module fmps_stream_capture
  import fmps_capture_pkg::*;
#(
  parameter int INDEX_WIDTH = 5,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                        sysClk,
  input  logic                        sysReset,
  input  logic                        FAstrobe,
  input  logic [INDEX_WIDTH-1:0]      packetIndex,
  input  logic [DATA_WIDTH-1:0]       packetData,
  input  logic                        packetValid,
  input  logic                        readoutHold,
  input  logic                        csrStrobe,
  input  logic [31:0]                 GPIO_OUT,
  input  logic [INDEX_WIDTH-1:0]      readoutAddress,
  output logic [DATA_WIDTH-1:0]       readoutData,
  output logic                        readoutPresent,
  output logic [(1<<INDEX_WIDTH)-1:0] bitmap,
  output logic                        frameStrobe,
  output logic [31:0]                 csr
);

  localparam int SLOTS = 1 << INDEX_WIDTH;

  // The unique-slot count field is 10 bits wide, which bounds the frame size.
  if (INDEX_WIDTH > 9) begin : g_width_check
    $error("fmps_stream_capture: INDEX_WIDTH must be <= 9");
  end

  fsm_state_t                     state;
  logic                           wr_bank;
  logic [SLOTS-1:0]               wr_bitmap;
  logic [CSR_COUNT_WIDTH-1:0]     wr_count;
  logic                           wr_dup;
  logic [CSR_COUNT_WIDTH-1:0]     commit_count;
  logic                           commit_dup;
  logic                           commit_valid;
  logic [CSR_FRAME_WIDTH-1:0]     frame_count;
  logic [CSR_OVERRUN_WIDTH-1:0]   overrun_count;

  logic                           boundary;
  logic                           do_commit;
  logic                           do_overrun;
  logic                           accept;
  logic                           clear_overrun;
  logic                           wr_bank_next;
  logic [SLOTS-1:0]               wr_bitmap_next;
  logic [CSR_COUNT_WIDTH-1:0]     wr_count_next;
  logic                           wr_dup_next;
  logic [DATA_WIDTH-1:0]          ram_q;
  logic                           unused_gpio;

  assign boundary      = (state == FSM_COLLECT) && FAstrobe;
  assign do_commit     = boundary && !readoutHold;
  assign do_overrun    = boundary && readoutHold;
  assign clear_overrun = csrStrobe && GPIO_OUT[GPIO_CLEAR_BIT];
  assign unused_gpio   = ^GPIO_OUT[31:1];

  // A packet coinciding with FAstrobe belongs to the frame that the strobe
  // opens, including the very first strobe that leaves WAIT_SYNC.
  assign accept = packetValid && ((state == FSM_COLLECT) || FAstrobe);

  // Write-side next state: a strobe clears the frame first, then the
  // coincident packet (if any) is folded into the freshly cleared frame.
  always_comb begin
    wr_bank_next   = do_commit ? ~wr_bank : wr_bank;
    wr_bitmap_next = FAstrobe ? '0 : wr_bitmap;
    wr_count_next  = FAstrobe ? '0 : wr_count;
    wr_dup_next    = FAstrobe ? 1'b0 : wr_dup;
    if (accept) begin
      if (wr_bitmap_next[packetIndex]) begin
        wr_dup_next = 1'b1;
      end else begin
        wr_count_next = wr_count_next + CSR_COUNT_WIDTH'(1);
      end
      wr_bitmap_next[packetIndex] = 1'b1;
    end
  end

  // Writes go to the post-flip bank, reads to the committed bank (~wr_bank).
  // On a commit cycle both address the same bank; the RAM's read-before-write
  // keeps the read returning the frame that was committed until this edge.
  fmps_capture_dpram #(
    .ADDR_WIDTH (INDEX_WIDTH + 1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_dpram (
    .clk     (sysClk),
    .wr_en   (accept),
    .wr_addr ({wr_bank_next, packetIndex}),
    .wr_data (packetData),
    .rd_addr ({~wr_bank, readoutAddress}),
    .rd_data (ram_q)
  );

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state          <= FSM_WAIT_SYNC;
      wr_bank        <= 1'b0;
      wr_bitmap      <= '0;
      wr_count       <= '0;
      wr_dup         <= 1'b0;
      bitmap         <= '0;
      commit_count   <= '0;
      commit_dup     <= 1'b0;
      commit_valid   <= 1'b0;
      frame_count    <= '0;
      overrun_count  <= '0;
      frameStrobe    <= 1'b0;
      readoutPresent <= 1'b0;
    end else begin
      case (state)
        FSM_WAIT_SYNC: begin
          if (FAstrobe) begin
            state <= FSM_COLLECT;
          end
        end
        FSM_COLLECT: begin
          if (do_commit) begin
            bitmap       <= wr_bitmap;
            commit_count <= wr_count;
            commit_dup   <= wr_dup;
            commit_valid <= 1'b1;
            frame_count  <= frame_count + CSR_FRAME_WIDTH'(1);
          end
        end
        default: state <= FSM_WAIT_SYNC;
      endcase

      wr_bank        <= wr_bank_next;
      wr_bitmap      <= wr_bitmap_next;
      wr_count       <= wr_count_next;
      wr_dup         <= wr_dup_next;
      frameStrobe    <= do_commit;
      // Presence is sampled from the same bitmap the RAM read is aligned to.
      readoutPresent <= bitmap[readoutAddress];

      // A clear coinciding with an overrun wins.
      if (clear_overrun) begin
        overrun_count <= '0;
      end else if (do_overrun && (overrun_count != OVERRUN_SAT)) begin
        overrun_count <= overrun_count + CSR_OVERRUN_WIDTH'(1);
      end
    end
  end

  assign readoutData = readoutPresent ? ram_q : '0;

  assign csr = pack_csr(wr_count != '0, commit_valid, commit_dup,
                        overrun_count, frame_count, commit_count);

endmodule
`default_nettype wire

// File: tb/tb_fmps_stream_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmps_stream_capture
// Purpose  : Self-checking bench for fmps_stream_capture: directed scenarios
//            followed by randomized traffic, all compared cycle by cycle
//            against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fmps_stream_capture;

  localparam int IW    = 5;
  localparam int DW    = 32;
  localparam int SLOTS = 1 << IW;

  logic             clk = 1'b0;
  logic             rst, fa, pv, hold, cs;
  logic [IW-1:0]    pidx, raddr;
  logic [DW-1:0]    pdata, rdata;
  logic [31:0]      gpio, csr;
  logic             pres, fs;
  logic [SLOTS-1:0] bm;

  always #5 clk = ~clk;

  fmps_stream_capture #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW)) dut (
    .sysClk         (clk),
    .sysReset       (rst),
    .FAstrobe       (fa),
    .packetIndex    (pidx),
    .packetData     (pdata),
    .packetValid    (pv),
    .readoutHold    (hold),
    .csrStrobe      (cs),
    .GPIO_OUT       (gpio),
    .readoutAddress (raddr),
    .readoutData    (rdata),
    .readoutPresent (pres),
    .bitmap         (bm),
    .frameStrobe    (fs),
    .csr            (csr)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame-level reference model: the frame being collected and the frame
  // last committed, as plain arrays.
  bit          m_synced;
  logic [DW-1:0] cur_data [SLOTS];
  bit          cur_pres [SLOTS];
  bit          cur_dup;
  logic [DW-1:0] com_data [SLOTS];
  bit          com_pres [SLOTS];
  bit          com_dup, com_valid;
  int          com_count, frames, overruns;

  task automatic model_reset();
    m_synced = 0; cur_dup = 0; com_dup = 0; com_valid = 0;
    com_count = 0; frames = 0; overruns = 0;
    for (int i = 0; i < SLOTS; i++) begin
      cur_pres[i] = 0; com_pres[i] = 0;
    end
  endtask

  function automatic int cur_count();
    int n = 0;
    for (int i = 0; i < SLOTS; i++) n += cur_pres[i];
    return n;
  endfunction

  function automatic logic [31:0] exp_csr();
    logic [31:0] w;
    w = (cur_count() != 0) ? 32'h8000_0000 : 32'h0;
    if (com_valid) w = w | 32'h4000_0000;
    if (com_dup)   w = w | 32'h2000_0000;
    w = w | (32'(overruns) << 20) | (32'(frames) << 12) | 32'(com_count);
    return w;
  endfunction

  function automatic logic [SLOTS-1:0] exp_bitmap();
    logic [SLOTS-1:0] b = '0;
    for (int i = 0; i < SLOTS; i++) b[i] = com_pres[i];
    return b;
  endfunction

  // Advance the model with the currently driven inputs, clock once, compare.
  task automatic tick();
    logic [DW-1:0] e_data;
    bit e_pres, e_fs;
    e_fs = 0;
    if (rst) begin
      model_reset();
      e_pres = 0; e_data = '0;
    end else begin
      e_pres = com_pres[raddr];
      e_data = e_pres ? com_data[raddr] : '0;
      if (fa) begin
        if (!m_synced) m_synced = 1;
        else if (!hold) begin
          for (int i = 0; i < SLOTS; i++) begin
            com_data[i] = cur_data[i]; com_pres[i] = cur_pres[i];
          end
          com_dup = cur_dup; com_count = cur_count(); com_valid = 1;
          frames = (frames + 1) % 256; e_fs = 1;
        end else if (overruns < 255) overruns++;
        for (int i = 0; i < SLOTS; i++) cur_pres[i] = 0;
        cur_dup = 0;
      end
      if (cs && gpio[0]) overruns = 0;
      if (pv && m_synced) begin
        if (cur_pres[pidx]) cur_dup = 1;
        cur_pres[pidx] = 1;
        cur_data[pidx] = pdata;
      end
    end
    @(posedge clk); #1;
    chk("frameStrobe",    fs,    e_fs);
    chk("csr",            csr,   exp_csr());
    chk("bitmap",         bm,    exp_bitmap());
    chk("readoutPresent", pres,  e_pres);
    chk("readoutData",    rdata, e_data);
  endtask

  task automatic idle();
    fa = 0; pv = 0; cs = 0; hold = 0;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    rst = 1; fa = 0; pv = 0; hold = 0; cs = 0;
    pidx = '0; pdata = '0; gpio = '0; raddr = '0;
    model_reset();

    // Reset state
    do_reset();
    chk("reset_csr",    csr,   32'h0);
    chk("reset_bitmap", bm,    32'h0);
    chk("reset_fs",     fs,    1'b0);
    chk("reset_rdata",  rdata, 32'h0);
    chk("reset_pres",   pres,  1'b0);

    // Full frame of 32 slots
    fa = 1; tick(); fa = 0;
    pv = 1;
    for (int i = 0; i < SLOTS; i++) begin
      pidx = IW'(i); pdata = 32'h100 + 32'(i); tick();
    end
    pv = 0; fa = 1; tick(); fa = 0;
    chk("full_fs",     fs,        1'b1);
    chk("full_valid",  csr[30],   1'b1);
    chk("full_count",  csr[9:0],  10'd32);
    chk("full_bitmap", bm,        32'hFFFF_FFFF);
    raddr = 5'd7; tick();
    chk("full_rd7",    rdata,     32'h107);
    chk("full_pres7",  pres,      1'b1);

    // Packets before sync are ignored; then an empty frame
    do_reset();
    pv = 1;
    for (int i = 0; i < 5; i++) begin
      pidx = IW'($urandom); pdata = $urandom; tick();
    end
    pv = 0; fa = 1; tick(); tick(); fa = 0;
    chk("empty_count",  csr[9:0], 10'd0);
    chk("empty_valid",  csr[30],  1'b1);
    chk("empty_bitmap", bm,       32'h0);
    raddr = 5'd3; tick();
    chk("empty_rdata",  rdata,    32'h0);
    chk("empty_pres",   pres,     1'b0);

    // Duplicate slot 3
    pv = 1; pidx = 5'd3; pdata = 32'hAAAA; tick();
    pdata = 32'hBBBB; tick(); pv = 0;
    fa = 1; tick(); fa = 0;
    chk("dup_count", csr[9:0], 10'd1);
    chk("dup_flag",  csr[29],  1'b1);
    tick();
    chk("dup_rd3",   rdata,    32'hBBBB);

    // Packet coincident with FAstrobe belongs to the next frame
    do_reset();
    fa = 1; tick(); fa = 0;
    pv = 1; pidx = 5'd1; pdata = 32'h11; tick();
    pidx = 5'd5; pdata = 32'h55; fa = 1; tick(); fa = 0; pv = 0;
    chk("coin_absent",  bm[5], 1'b0);
    chk("coin_other",   bm[1], 1'b1);
    fa = 1; tick(); fa = 0;
    chk("coin_present", bm[5], 1'b1);
    raddr = 5'd5; tick();
    chk("coin_rd5",     rdata, 32'h55);

    // Overruns under readoutHold, then CSR clear
    do_reset();
    fa = 1; tick(); tick(); fa = 0;
    hold = 1;
    for (int k = 0; k < 3; k++) begin
      pv = 1; pidx = IW'(k); pdata = $urandom;
      fa = 1; tick(); fa = 0; tick();
    end
    pv = 0; hold = 0;
    chk("ovr_count",  csr[27:20], 8'd3);
    chk("ovr_frames", csr[19:12], 8'd1);
    chk("ovr_bitmap", bm,         32'h0);
    cs = 1; gpio = 32'h1; tick(); cs = 0;
    chk("ovr_clear",  csr[27:20], 8'd0);

    // Frame counter wrap and overrun saturation
    do_reset();
    fa = 1; tick();
    for (int k = 0; k < 300; k++) tick();
    chk("wrap_frames", csr[19:12], 8'd44);
    hold = 1;
    for (int k = 0; k < 300; k++) tick();
    chk("sat_overrun", csr[27:20], 8'd255);
    chk("sat_frames",  csr[19:12], 8'd44);
    idle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 499) == 0);
      fa    = ($urandom_range(0, 11) == 0);
      pv    = ($urandom_range(0, 3) != 0);
      pidx  = IW'($urandom);
      pdata = $urandom;
      hold  = ($urandom_range(0, 4) == 0);
      cs    = ($urandom_range(0, 19) == 0);
      gpio  = $urandom;
      raddr = IW'($urandom);
      tick();
    end
    rst = 0; idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
